// File: rtl/spi_slave_fifo_ctrl_pkg.sv
// Shared register map, bit positions and FIFO word width for the SPI slave front end.
package spi_slave_fifo_ctrl_pkg;

  localparam int unsigned WordW = 64;
  localparam int unsigned RegW  = 32;

  // Register word indices
  localparam logic [2:0] AddrCtrl   = 3'd0;
  localparam logic [2:0] AddrStatus = 3'd1;
  localparam logic [2:0] AddrTxl    = 3'd2;
  localparam logic [2:0] AddrTxh    = 3'd3;
  localparam logic [2:0] AddrRxl    = 3'd4;
  localparam logic [2:0] AddrRxh    = 3'd5;

  // CTRL bit positions
  localparam int unsigned CtrlEn      = 0;
  localparam int unsigned CtrlCpol    = 1;
  localparam int unsigned CtrlCpha    = 2;
  localparam int unsigned CtrlMsb     = 3;
  localparam int unsigned CtrlBptLsb  = 4;
  localparam int unsigned CtrlBptW    = 6;
  localparam int unsigned CtrlTxie    = 10;
  localparam int unsigned CtrlRxie    = 11;
  localparam int unsigned CtrlTxFlush = 12;
  localparam int unsigned CtrlRxFlush = 13;
  // Flush bits are strobes, so only [11:0] are stored
  localparam int unsigned CtrlStoredW = 12;

  // STATUS bit positions
  localparam int unsigned StatTxFull   = 0;
  localparam int unsigned StatTxEmpty  = 1;
  localparam int unsigned StatRxFull   = 2;
  localparam int unsigned StatRxEmpty  = 3;
  localparam int unsigned StatBusy     = 4;
  localparam int unsigned StatRxOvf    = 5;
  localparam int unsigned StatTxUnder  = 6;
  localparam int unsigned StatTxCntLsb = 8;
  localparam int unsigned StatRxCntLsb = 16;

endpackage

// File: rtl/spi_slave_fifo_ctrl_fifo.sv
// DEPTH x 64 synchronous FIFO with show-ahead head, flush, and push/pop on full and empty.
// A push and pop together on an empty FIFO pass the pushed word straight through.
module spi_word_fifo
  import spi_slave_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WordW-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic [WordW-1:0] o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WordW-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_count = count_q;
  assign o_head  = o_empty ? i_wdata : mem_q[rd_ptr_q];

  // Pop on empty is only meaningful as a bypass of a same-cycle push
  assign do_pop  = i_pop & (~o_empty | i_push);
  assign do_push = i_push & (~o_full | do_pop);

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointers and count; flush overrides any push/pop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/spi_slave_fifo_ctrl.sv
// Register-bus front end for the SPI slave: config register, TX/RX word FIFOs, status, IRQ.
module spi_slave_fifo_ctrl
  import spi_slave_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_addr,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq,
  output logic        o_EN_SPI,
  output logic        o_CPOL_SPI,
  output logic        o_CPHA_SPI,
  output logic        o_MSB_SPI,
  output logic [5:0]  o_BPT_SPI,
  output logic [31:0] o_TXDATAL_SPI,
  output logic [31:0] o_TXDATAH_SPI,
  input  logic        i_TXE_SPI,
  input  logic        i_RXNE_SPI,
  input  logic        i_BUSY_SPI,
  input  logic [31:0] i_RXDATAL_SPI,
  input  logic [31:0] i_RXDATAH_SPI
);

  logic [CtrlStoredW-1:0] ctrl_q;
  logic [RegW-1:0]        txl_q, rdata_q, rdata_d, status;
  logic                   irq_q, irq_d;
  logic                   txe_q, rxne_q, rxovf_q, txunder_q;
  logic [WordW-1:0]       tx_cur_q;
  logic                   tx_cur_valid_q;

  logic             wr_ctrl, wr_status, wr_txl, wr_txh, rd_rxh;
  logic             tx_flush, rx_flush, txe_evt, rxne_evt;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]    tx_count, rx_count;
  logic [WordW-1:0] tx_head, rx_head;
  logic             tx_prime, tx_next_avail, tx_load, tx_under_evt;
  logic             rx_pop, rx_ovf_evt;

  assign wr_ctrl   = i_we & (i_addr == AddrCtrl);
  assign wr_status = i_we & (i_addr == AddrStatus);
  assign wr_txl    = i_we & (i_addr == AddrTxl);
  assign wr_txh    = i_we & (i_addr == AddrTxh);
  assign rd_rxh    = i_re & (i_addr == AddrRxh);
  assign tx_flush  = wr_ctrl & i_wdata[CtrlTxFlush];
  assign rx_flush  = wr_ctrl & i_wdata[CtrlRxFlush];

  assign txe_evt   = i_TXE_SPI & ~txe_q;
  assign rxne_evt  = i_RXNE_SPI & ~rxne_q;

  // TX sequencing: an event takes the next word (including a same-cycle push into an empty
  // FIFO, via the FIFO bypass); otherwise prime an idle slot only while the slave is idle.
  assign tx_prime      = ~tx_cur_valid_q & ~tx_empty & ~i_BUSY_SPI;
  assign tx_next_avail = ~tx_empty | wr_txh;
  assign tx_load       = ~tx_flush & (txe_evt ? tx_next_avail : tx_prime);
  assign tx_under_evt  = ~tx_flush & txe_evt & ~tx_next_avail;

  assign rx_pop     = rd_rxh & ~rx_empty;
  assign rx_ovf_evt = rxne_evt & rx_full & ~rx_pop & ~rx_flush;

  spi_word_fifo #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_tx_fifo (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_push (wr_txh),
    .i_wdata({i_wdata, txl_q}),
    .i_pop  (tx_load),
    .i_flush(tx_flush),
    .o_full (tx_full),
    .o_empty(tx_empty),
    .o_count(tx_count),
    .o_head (tx_head)
  );

  spi_word_fifo #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_rx_fifo (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_push (rxne_evt),
    .i_wdata({i_RXDATAH_SPI, i_RXDATAL_SPI}),
    .i_pop  (rx_pop),
    .i_flush(rx_flush),
    .o_full (rx_full),
    .o_empty(rx_empty),
    .o_count(rx_count),
    .o_head (rx_head)
  );

  // Configuration register and TX low-word staging
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q <= '0;
      txl_q  <= '0;
    end else begin
      if (wr_ctrl) ctrl_q <= i_wdata[CtrlStoredW-1:0];
      if (wr_txl)  txl_q  <= i_wdata;
    end
  end

  // Previous levels of the slave flags for rising-edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      txe_q  <= 1'b0;
      rxne_q <= 1'b0;
    end else begin
      txe_q  <= i_TXE_SPI;
      rxne_q <= i_RXNE_SPI;
    end
  end

  // Current TX word presented to the slave; data holds when the slot empties
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_cur_q       <= '0;
      tx_cur_valid_q <= 1'b0;
    end else if (tx_flush) begin
      tx_cur_valid_q <= 1'b0;
    end else if (tx_load) begin
      tx_cur_q       <= tx_head;
      tx_cur_valid_q <= 1'b1;
    end else if (tx_under_evt) begin
      tx_cur_valid_q <= 1'b0;
    end
  end

  // Sticky error flags; a new event wins over a same-cycle clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rxovf_q   <= 1'b0;
      txunder_q <= 1'b0;
    end else begin
      if (rx_ovf_evt) begin
        rxovf_q <= 1'b1;
      end else if (wr_status && i_wdata[StatRxOvf]) begin
        rxovf_q <= 1'b0;
      end
      if (tx_under_evt) begin
        txunder_q <= 1'b1;
      end else if (wr_status && i_wdata[StatTxUnder]) begin
        txunder_q <= 1'b0;
      end
    end
  end

  // Status word and read mux
  always_comb begin
    status                            = '0;
    status[StatTxFull]                = tx_full;
    status[StatTxEmpty]               = tx_empty;
    status[StatRxFull]                = rx_full;
    status[StatRxEmpty]               = rx_empty;
    status[StatBusy]                  = i_BUSY_SPI;
    status[StatRxOvf]                 = rxovf_q;
    status[StatTxUnder]               = txunder_q;
    status[StatTxCntLsb +: CW]        = tx_count;
    status[StatRxCntLsb +: CW]        = rx_count;

    rdata_d = '0;
    case (i_addr)
      AddrCtrl:   rdata_d = RegW'(ctrl_q);
      AddrStatus: rdata_d = status;
      AddrRxl:    rdata_d = rx_empty ? '0 : rx_head[31:0];
      AddrRxh:    rdata_d = rx_empty ? '0 : rx_head[63:32];
      default:    rdata_d = '0;
    endcase

    irq_d = (ctrl_q[CtrlTxie] & tx_empty & ~tx_cur_valid_q) |
            (ctrl_q[CtrlRxie] & ~rx_empty) | rxovf_q | txunder_q;
  end

  // Registered read data and interrupt
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (i_re) rdata_q <= rdata_d;
      irq_q <= irq_d;
    end
  end

  assign o_rdata       = rdata_q;
  assign o_irq         = irq_q;
  assign o_EN_SPI      = ctrl_q[CtrlEn];
  assign o_CPOL_SPI    = ctrl_q[CtrlCpol];
  assign o_CPHA_SPI    = ctrl_q[CtrlCpha];
  assign o_MSB_SPI     = ctrl_q[CtrlMsb];
  assign o_BPT_SPI     = ctrl_q[CtrlBptLsb +: CtrlBptW];
  assign o_TXDATAL_SPI = tx_cur_q[31:0];
  assign o_TXDATAH_SPI = tx_cur_q[63:32];

endmodule

// File: tb/tb_spi_slave_fifo_ctrl.sv
// Directed bench for spi_slave_fifo_ctrl: table-driven register accesses plus hand sequences.
module tb_spi_slave_fifo_ctrl;

  logic        i_clk, i_rst_n;
  logic [2:0]  i_addr;
  logic        i_we, i_re;
  logic [31:0] i_wdata, o_rdata;
  logic        o_irq, o_EN_SPI, o_CPOL_SPI, o_CPHA_SPI, o_MSB_SPI;
  logic [5:0]  o_BPT_SPI;
  logic [31:0] o_TXDATAL_SPI, o_TXDATAH_SPI;
  logic        i_TXE_SPI, i_RXNE_SPI, i_BUSY_SPI;
  logic [31:0] i_RXDATAL_SPI, i_RXDATAH_SPI;

  spi_slave_fifo_ctrl #(
    .DEPTH(4),
    .CW   (3)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_addr       (i_addr),
    .i_we         (i_we),
    .i_re         (i_re),
    .i_wdata      (i_wdata),
    .o_rdata      (o_rdata),
    .o_irq        (o_irq),
    .o_EN_SPI     (o_EN_SPI),
    .o_CPOL_SPI   (o_CPOL_SPI),
    .o_CPHA_SPI   (o_CPHA_SPI),
    .o_MSB_SPI    (o_MSB_SPI),
    .o_BPT_SPI    (o_BPT_SPI),
    .o_TXDATAL_SPI(o_TXDATAL_SPI),
    .o_TXDATAH_SPI(o_TXDATAH_SPI),
    .i_TXE_SPI    (i_TXE_SPI),
    .i_RXNE_SPI   (i_RXNE_SPI),
    .i_BUSY_SPI   (i_BUSY_SPI),
    .i_RXDATAL_SPI(i_RXDATAL_SPI),
    .i_RXDATAH_SPI(i_RXDATAH_SPI)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  localparam logic [2:0] ACtrl = 3'd0, AStat = 3'd1, ATxl = 3'd2, ATxh = 3'd3;
  localparam logic [2:0] ARxl  = 3'd4, ARxh  = 3'd5;

  typedef struct {
    int          grp;
    logic        we;
    logic        re;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic void add(input int g, input logic we, input logic re,
                              input logic [2:0] a, input logic [31:0] wd,
                              input logic [31:0] ex);
    vec_t v;
    v.grp = g; v.we = we; v.re = re; v.addr = a; v.wdata = wd; v.exp = ex;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // One bus cycle, starting and ending at a negedge; o_rdata is valid on return
  task automatic bus(input logic we, input logic re, input logic [2:0] a, input logic [31:0] wd);
    i_we = we; i_re = re; i_addr = a; i_wdata = wd;
    tick();
    i_we = 1'b0; i_re = 1'b0; i_addr = 3'd0; i_wdata = '0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] ex);
    bus(1'b0, 1'b1, a, '0);
    check(name, {32'b0, o_rdata}, {32'b0, ex});
  endtask

  task automatic push_tx(input logic [31:0] h, input logic [31:0] l);
    bus(1'b1, 1'b0, ATxl, l);
    bus(1'b1, 1'b0, ATxh, h);
  endtask

  task automatic rx_word(input logic [31:0] n);
    i_RXDATAL_SPI = n; i_RXDATAH_SPI = 32'h1000 | n; i_RXNE_SPI = 1'b1;
    tick();
    i_RXNE_SPI = 1'b0;
    tick();
  endtask

  task automatic run_grp(input int g);
    foreach (vecs[i]) begin
      if (vecs[i].grp == g) begin
        bus(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
        if (vecs[i].re)
          check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), {32'b0, o_rdata},
                {32'b0, vecs[i].exp});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Group 0: post-reset register view and CTRL write
    add(0, 0, 1, AStat, 0, 32'h0000_000A);
    add(0, 0, 1, ACtrl, 0, 32'h0);
    add(0, 0, 1, ARxl,  0, 32'h0);
    add(0, 0, 1, 3'd6,  0, 32'h0);
    add(0, 0, 1, 3'd7,  0, 32'h0);
    add(0, 1, 0, ACtrl, 32'h81, 0);
    add(0, 0, 1, ACtrl, 0, 32'h81);
    // Group 1: RX FIFO after overflow, drained in order
    add(1, 0, 1, AStat, 0, 32'h0004_0026);
    for (int n = 1; n <= 4; n++) begin
      add(1, 0, 1, ARxl, 0, n);
      add(1, 0, 1, ARxh, 0, 32'h1000 | n);
    end
    add(1, 0, 1, ARxl,  0, 32'h0);
    add(1, 0, 1, ARxh,  0, 32'h0);
    add(1, 0, 1, AStat, 0, 32'h0000_002A);
    add(1, 1, 0, AStat, 32'h20, 0);
    add(1, 0, 1, AStat, 0, 32'h0000_000A);

    i_rst_n = 1'b0; i_addr = '0; i_we = 0; i_re = 0; i_wdata = '0;
    i_TXE_SPI = 0; i_RXNE_SPI = 0; i_BUSY_SPI = 0; i_RXDATAL_SPI = '0; i_RXDATAH_SPI = '0;
    repeat (2) tick();
    check("rst_en", {63'b0, o_EN_SPI}, 64'd0);
    check("rst_irq", {63'b0, o_irq}, 64'd0);
    check("rst_txdata", {o_TXDATAH_SPI, o_TXDATAL_SPI}, 64'd0);
    i_rst_n = 1'b1;

    // Test 1: reset view, CTRL
    run_grp(0);
    check("irq_idle", {63'b0, o_irq}, 64'd0);
    check("cfg_en_bpt", {56'b0, o_BPT_SPI, o_MSB_SPI, o_EN_SPI}, {56'b0, 6'd8, 1'b0, 1'b1});

    // Test 2: prime with slave idle
    push_tx(32'h0, 32'h11);
    tick();
    check("prime_data", {o_TXDATAH_SPI, o_TXDATAL_SPI}, 64'h11);
    rd_chk("prime_status", AStat, 32'h0000_000A);

    // Test 3: TXE level counts once, then underrun
    bus(1'b1, 1'b0, ACtrl, 32'h1081);
    rd_chk("txflush_selfclr", ACtrl, 32'h81);
    push_tx(32'hAAAA_0002, 32'hAAAA_0001);
    push_tx(32'hBBBB_0002, 32'hBBBB_0001);
    tick();
    check("tx_word_a", {o_TXDATAH_SPI, o_TXDATAL_SPI}, 64'hAAAA_0002_AAAA_0001);
    i_BUSY_SPI = 1'b1;
    rd_chk("tx_cnt1_busy", AStat, 32'h0000_0118);
    i_TXE_SPI = 1'b1;
    repeat (3) tick();
    i_TXE_SPI = 1'b0;
    check("tx_word_b", {o_TXDATAH_SPI, o_TXDATAL_SPI}, 64'hBBBB_0002_BBBB_0001);
    rd_chk("txe_single_pop", AStat, 32'h0000_001A);
    i_TXE_SPI = 1'b1;
    tick();
    i_TXE_SPI = 1'b0;
    tick();
    check("under_irq", {63'b0, o_irq}, 64'd1);
    check("under_hold", {o_TXDATAH_SPI, o_TXDATAL_SPI}, 64'hBBBB_0002_BBBB_0001);
    rd_chk("under_status", AStat, 32'h0000_005A);
    bus(1'b1, 1'b0, AStat, 32'h40);
    rd_chk("under_w1c", AStat, 32'h0000_001A);
    check("under_irq_clr", {63'b0, o_irq}, 64'd0);

    // TXE event in the same cycle as a push into an empty FIFO
    bus(1'b1, 1'b0, ATxl, 32'hC1);
    i_we = 1'b1; i_addr = ATxh; i_wdata = 32'hC2; i_TXE_SPI = 1'b1;
    tick();
    i_we = 1'b0; i_addr = '0; i_wdata = '0; i_TXE_SPI = 1'b0;
    check("txe_push_bypass", {o_TXDATAH_SPI, o_TXDATAL_SPI}, 64'h0000_00C2_0000_00C1);
    rd_chk("txe_push_status", AStat, 32'h0000_001A);

    // Test 4: RX fill, overflow, in-order drain
    i_BUSY_SPI = 1'b0;
    for (int n = 1; n <= 5; n++) rx_word(n);
    check("rx_ovf_irq", {63'b0, o_irq}, 64'd1);
    run_grp(1);

    // Test 5: RXNE event on full FIFO together with an RXH pop
    for (int n = 32'h21; n <= 32'h24; n++) rx_word(n);
    i_re = 1'b1; i_addr = ARxh;
    i_RXDATAL_SPI = 32'h25; i_RXDATAH_SPI = 32'h1025; i_RXNE_SPI = 1'b1;
    tick();
    i_re = 1'b0; i_addr = '0; i_RXNE_SPI = 1'b0;
    check("rx_popush_rdata", {32'b0, o_rdata}, 64'h1021);
    rd_chk("rx_popush_status", AStat, 32'h0004_0006);
    for (int n = 32'h22; n <= 32'h25; n++) begin
      rd_chk($sformatf("rx2_l%0h", n), ARxl, n);
      rd_chk($sformatf("rx2_h%0h", n), ARxh, 32'h1000 | n);
    end
    rd_chk("rx2_drained", AStat, 32'h0000_000A);

    // Test 6: asynchronous reset mid-transfer with both FIFOs partly full
    i_BUSY_SPI = 1'b1;
    rx_word(32'h31);
    rx_word(32'h32);
    push_tx(32'hE2, 32'hE1);
    push_tx(32'hF2, 32'hF1);
    rd_chk("pre_rst_status", AStat, 32'h0002_0210);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst_en", {63'b0, o_EN_SPI}, 64'd0);
    check("async_rst_bpt", {58'b0, o_BPT_SPI}, 64'd0);
    check("async_rst_rdata", {32'b0, o_rdata}, 64'd0);
    check("async_rst_txdata", {o_TXDATAH_SPI, o_TXDATAL_SPI}, 64'd0);
    tick();
    i_rst_n = 1'b1;
    rd_chk("post_rst_status", AStat, 32'h0000_001A);
    rd_chk("post_rst_ctrl", ACtrl, 32'h0);

    // TXFLUSH while a word is current: FIFO empties and slot goes idle
    i_BUSY_SPI = 1'b0;
    bus(1'b1, 1'b0, ACtrl, 32'h81);
    push_tx(32'hD2, 32'hD1);
    push_tx(32'hE2, 32'hE1);
    push_tx(32'hF2, 32'hF1);
    check("flush_pre_data", {o_TXDATAH_SPI, o_TXDATAL_SPI}, 64'h0000_00D2_0000_00D1);
    rd_chk("flush_pre_status", AStat, 32'h0000_0208);
    bus(1'b1, 1'b0, ACtrl, 32'h1481);
    rd_chk("flush_status", AStat, 32'h0000_000A);
    check("flush_idle_irq", {63'b0, o_irq}, 64'd1);
    rd_chk("flush_ctrl", ACtrl, 32'h481);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
